// File: rtl/up_core_pkg.sv
// ============================================================================
// Module      : up_core_pkg
// Description : Shared types, encodings and immediate helpers for the
//               multicycle RV-subset core (optional MUL: UP_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package up_core_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        WRITEBACK = 3'd3,
        HALT      = 3'd4
    } state_t;

    typedef enum logic [2:0] {
        ALU_ADD   = 3'd0,
        ALU_SUB   = 3'd1,
        ALU_SLT   = 3'd2,
        ALU_XOR   = 3'd3,
        ALU_OR    = 3'd4,
        ALU_AND   = 3'd5,
        ALU_PASSB = 3'd6,
        ALU_MUL   = 3'd7
    } alu_op_t;

    localparam logic [6:0] c_op_rtype  = 7'b0110011;
    localparam logic [6:0] c_op_itype  = 7'b0010011;
    localparam logic [6:0] c_op_lui    = 7'b0110111;
    localparam logic [6:0] c_op_branch = 7'b1100011;

    localparam logic [2:0] c_f3_add = 3'b000;
    localparam logic [2:0] c_f3_slt = 3'b010;
    localparam logic [2:0] c_f3_xor = 3'b100;
    localparam logic [2:0] c_f3_or  = 3'b110;
    localparam logic [2:0] c_f3_and = 3'b111;
    localparam logic [2:0] c_f3_beq = 3'b000;
    localparam logic [2:0] c_f3_bne = 3'b001;

    localparam logic [6:0] c_f7_base = 7'b0000000;
    localparam logic [6:0] c_f7_sub  = 7'b0100000;
    localparam logic [6:0] c_f7_mul  = 7'b0000001;

    // Immediates are returned as signed 32-bit values; callers widen to XLEN.
    function automatic logic [31:0] imm_i(input logic [31:0] ir);
        return {{20{ir[31]}}, ir[31:20]};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] ir);
        return {ir[31:12], 12'b0};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] ir);
        return {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    endfunction

endpackage

`default_nettype wire

// File: rtl/up_alu.sv
// ============================================================================
// Module      : up_alu
// Description : Combinational ALU for the multicycle core; the MUL operation
//               is present only when UP_MUL_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module up_alu
    import up_core_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  alu_op_t         op,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLT:   result = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_XOR:   result = a ^ b;
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
`ifdef UP_MUL_EN
            ALU_MUL:   result = a * b;
`endif
            default:   result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/up_multicycle_core.sv
// ============================================================================
// Module      : up_multicycle_core
// Description : Multicycle RV-subset core (fetch/decode/execute/writeback)
//               with variable-latency fetch; optional MUL via UP_MUL_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module up_multicycle_core
    import up_core_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic [31:0]     imem_addr,
    output logic            imem_req,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_valid,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] alu_out,
    output logic [2:0]      state_out,
    output logic            retire,
    output logic            halt,
    input  logic [4:0]      dbg_raddr,
    output logic [XLEN-1:0] dbg_rdata
);

    localparam int c_idx_w = $clog2(NREGS);

    state_t          r_state;
    state_t          w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_oldpc;
    logic [XLEN-1:0] r_a;
    logic [XLEN-1:0] r_b;
    logic [XLEN-1:0] r_alu;
    logic [31:0]     r_ir;
    logic [XLEN-1:0] r_regs [NREGS];

    logic [6:0]      w_opcode;
    logic [4:0]      w_rd;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_fn_ok;
    logic            w_regs_ok;
    logic            w_legal;
    logic            w_use_imm;
    logic            w_is_branch;
    logic            w_taken;
    alu_op_t         w_alu_op;
    logic [XLEN-1:0] w_imm;
    logic [XLEN-1:0] w_alu_res;

    assign w_opcode = r_ir[6:0];
    assign w_rd     = r_ir[11:7];
    assign w_f3     = r_ir[14:12];
    assign w_rs1    = r_ir[19:15];
    assign w_rs2    = r_ir[24:20];
    assign w_f7     = r_ir[31:25];

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < 32'(NREGS);
    endfunction

    // x0 and indices beyond the implemented file both read as zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || !idx_ok(idx)) begin
            return '0;
        end
        return r_regs[idx[c_idx_w-1:0]];
    endfunction

    always_comb begin
        w_fn_ok     = 1'b0;
        w_regs_ok   = 1'b0;
        w_use_imm   = 1'b0;
        w_is_branch = 1'b0;
        w_alu_op    = ALU_ADD;
        w_imm       = '0;
        case (w_opcode)
            c_op_rtype: begin
                w_regs_ok = idx_ok(w_rs1) && idx_ok(w_rs2) && idx_ok(w_rd);
                if (w_f7 == c_f7_base) begin
                    w_fn_ok = 1'b1;
                    case (w_f3)
                        c_f3_add: w_alu_op = ALU_ADD;
                        c_f3_slt: w_alu_op = ALU_SLT;
                        c_f3_xor: w_alu_op = ALU_XOR;
                        c_f3_or:  w_alu_op = ALU_OR;
                        c_f3_and: w_alu_op = ALU_AND;
                        default:  w_fn_ok  = 1'b0;
                    endcase
                end else if (w_f7 == c_f7_sub && w_f3 == c_f3_add) begin
                    w_fn_ok  = 1'b1;
                    w_alu_op = ALU_SUB;
                end
`ifdef UP_MUL_EN
                else if (w_f7 == c_f7_mul && w_f3 == c_f3_add) begin
                    w_fn_ok  = 1'b1;
                    w_alu_op = ALU_MUL;
                end
`endif
            end
            c_op_itype: begin
                w_regs_ok = idx_ok(w_rs1) && idx_ok(w_rd);
                w_use_imm = 1'b1;
                w_imm     = XLEN'($signed(imm_i(r_ir)));
                w_fn_ok   = 1'b1;
                case (w_f3)
                    c_f3_add: w_alu_op = ALU_ADD;
                    c_f3_xor: w_alu_op = ALU_XOR;
                    c_f3_or:  w_alu_op = ALU_OR;
                    c_f3_and: w_alu_op = ALU_AND;
                    default:  w_fn_ok  = 1'b0;
                endcase
            end
            c_op_lui: begin
                w_regs_ok = idx_ok(w_rd);
                w_use_imm = 1'b1;
                w_imm     = XLEN'($signed(imm_u(r_ir)));
                w_fn_ok   = 1'b1;
                w_alu_op  = ALU_PASSB;
            end
            c_op_branch: begin
                w_regs_ok   = idx_ok(w_rs1) && idx_ok(w_rs2);
                w_is_branch = 1'b1;
                w_imm       = XLEN'($signed(imm_b(r_ir)));
                w_fn_ok     = (w_f3 == c_f3_beq) || (w_f3 == c_f3_bne);
            end
            default: ;
        endcase
    end

    assign w_legal = w_fn_ok && w_regs_ok;
    assign w_taken = (w_f3 == c_f3_beq) ? (r_a == r_b) : (r_a != r_b);

    up_alu #(
        .XLEN   (XLEN)
    ) u_alu (
        .a      (r_a),
        .b      (w_use_imm ? w_imm : r_b),
        .op     (w_alu_op),
        .result (w_alu_res)
    );

    // Strobes are forced low while rst is asserted, whatever state we were in.
    always_comb begin
        w_state_nxt = r_state;
        imem_req    = 1'b0;
        retire      = 1'b0;
        halt        = 1'b0;
        case (r_state)
            FETCH: begin
                imem_req = !rst;
                if (imem_valid) begin
                    w_state_nxt = DECODE;
                end
            end
            DECODE: begin
                w_state_nxt = w_legal ? EXECUTE : HALT;
            end
            EXECUTE: begin
                retire      = w_is_branch && !rst;
                w_state_nxt = w_is_branch ? FETCH : WRITEBACK;
            end
            WRITEBACK: begin
                retire      = !rst;
                w_state_nxt = FETCH;
            end
            HALT: begin
                halt = !rst;
            end
            default: w_state_nxt = FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= FETCH;
            r_pc    <= RESET_PC;
            r_oldpc <= RESET_PC;
            r_ir    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_alu   <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                FETCH: begin
                    if (imem_valid) begin
                        r_ir    <= imem_rdata;
                        r_oldpc <= r_pc;
                        r_pc    <= r_pc + XLEN'(4);
                    end
                end
                DECODE: begin
                    r_a <= rf_read(w_rs1);
                    r_b <= rf_read(w_rs2);
                end
                EXECUTE: begin
                    if (w_is_branch) begin
                        if (w_taken) begin
                            r_pc <= r_oldpc + w_imm;
                        end
                    end else begin
                        r_alu <= w_alu_res;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else if (r_state == WRITEBACK && w_rd != 5'd0) begin
            r_regs[w_rd[c_idx_w-1:0]] <= r_alu;
        end
    end

    assign imem_addr = r_pc[31:0];
    assign pc_out    = r_pc;
    assign alu_out   = r_alu;
    assign state_out = r_state;
    assign dbg_rdata = rf_read(dbg_raddr);

endmodule

`default_nettype wire

// File: tb/tb_up_multicycle_core.sv
// ============================================================================
// Module      : tb_up_multicycle_core
// Description : Scoreboard bench for up_multicycle_core with an ISA-level
//               reference model (MUL expectations follow UP_MUL_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_up_multicycle_core;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst;
    logic [31:0]     imem_addr;
    logic            imem_req;
    logic [31:0]     imem_rdata;
    logic            imem_valid;
    logic [XLEN-1:0] pc_out;
    logic [XLEN-1:0] alu_out;
    logic [2:0]      state_out;
    logic            retire;
    logic            halt;
    wire  [4:0]      dbg_raddr;
    logic [XLEN-1:0] dbg_rdata;

    logic [4:0] dbg_main = 5'd0;
    logic [4:0] dbg_mon  = 5'd0;
    logic       main_dbg_on = 1'b0;
    assign dbg_raddr = main_dbg_on ? dbg_main : dbg_mon;

    up_multicycle_core #(
        .XLEN       (XLEN),
        .NREGS      (32),
        .RESET_PC   (64'h0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .imem_addr  (imem_addr),
        .imem_req   (imem_req),
        .imem_rdata (imem_rdata),
        .imem_valid (imem_valid),
        .pc_out     (pc_out),
        .alu_out    (alu_out),
        .state_out  (state_out),
        .retire     (retire),
        .halt       (halt),
        .dbg_raddr  (dbg_raddr),
        .dbg_rdata  (dbg_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;
    bit garbage_en = 1'b1;

    typedef struct {
        int          exp_cyc;
        logic [63:0] pc_after;
        logic [4:0]  rd;
        logic [63:0] val;
        bit          wr;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] m_regs [32];
    logic [63:0] m_pc;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 64'h0;
        m_pc = 64'h0;
    endtask

    // Architectural effect of one instruction word; pushes the expected retire.
    task automatic model_step(input logic [31:0] w, input int c, output bit legal);
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic [6:0]  f7, opc;
        logic [63:0] a, b, res, ii, iu, ib, npc;
        bit          wr;
        int          lat;
        opc = w[6:0];   rd  = w[11:7];  f3 = w[14:12];
        rs1 = w[19:15]; rs2 = w[24:20]; f7 = w[31:25];
        a   = m_regs[rs1];
        b   = m_regs[rs2];
        ii  = {{52{w[31]}}, w[31:20]};
        iu  = {{32{w[31]}}, w[31:12], 12'h000};
        ib  = {{51{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
        legal = 1'b1; wr = 1'b1; lat = 4; res = 64'h0; npc = m_pc + 64'd4;
        case (opc)
            7'h33: begin
                if (f7 == 7'h00 && f3 == 3'd0)      res = a + b;
                else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
                else if (f7 == 7'h00 && f3 == 3'd2) res = ($signed(a) < $signed(b)) ? 64'd1 : 64'd0;
                else if (f7 == 7'h00 && f3 == 3'd4) res = a ^ b;
                else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
                else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
`ifdef UP_MUL_EN
                else if (f7 == 7'h01 && f3 == 3'd0) res = a * b;
`endif
                else legal = 1'b0;
            end
            7'h13: begin
                case (f3)
                    3'd0: res = a + ii;
                    3'd4: res = a ^ ii;
                    3'd6: res = a | ii;
                    3'd7: res = a & ii;
                    default: legal = 1'b0;
                endcase
            end
            7'h37: res = iu;
            7'h63: begin
                wr  = 1'b0;
                lat = 3;
                if (f3 == 3'd0)      begin if (a == b) npc = m_pc + ib; end
                else if (f3 == 3'd1) begin if (a != b) npc = m_pc + ib; end
                else legal = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (legal) begin
            if (wr && rd != 5'd0) m_regs[rd] = res;
            sb.push_back('{c + lat - 1, npc, rd, m_regs[rd], wr});
            m_pc = npc;
        end
    endtask

    // Serve one fetch: optional wait cycles, then present the word.
    task automatic issue(input logic [31:0] w, input int waits, output bit legal);
        int          t;
        logic [63:0] pc0;
        t = 0;
        legal = 1'b0;
        while (imem_req !== 1'b1 && t < 40) begin
            @(negedge clk);
            t++;
        end
        if (imem_req !== 1'b1) begin
            n_tests++;
            n_fail++;
            $display("FAIL fetch_timeout: imem_req=%b, expected 1", imem_req);
            return;
        end
        check64("fetch_addr", {32'h0, imem_addr}, {32'h0, m_pc[31:0]});
        pc0 = pc_out;
        for (int i = 0; i < waits; i++) begin
            imem_valid = 1'b0;
            imem_rdata = $urandom;
            @(negedge clk);
            check64("wait_req", {63'h0, imem_req}, 64'h1);
            check64("wait_pc", pc_out, pc0);
        end
        imem_rdata = w;
        imem_valid = 1'b1;
        model_step(w, cyc, legal);
        @(negedge clk);
        imem_rdata = $urandom;
        imem_valid = 1'b0;
        if (garbage_en && $urandom_range(0, 1) == 1) begin
            imem_valid = 1'b1;
            @(negedge clk);
            imem_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL idle_timeout: %0d retires pending, expected 0", sb.size());
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reg(input string name, input int idx, input logic [63:0] exp);
        dbg_main    = 5'(idx);
        main_dbg_on = 1'b1;
        #1;
        check64(name, dbg_rdata, exp);
        main_dbg_on = 1'b0;
    endtask

    function automatic logic [31:0] rand_insn();
        logic [4:0]  rd, rs1, rs2;
        logic [11:0] imm;
        logic [19:0] u;
        logic [12:0] off;
        int          k;
        rd  = 5'($urandom_range(0, 7));
        rs1 = 5'($urandom_range(0, 7));
        rs2 = 5'($urandom_range(0, 7));
        imm = 12'($urandom);
        u   = 20'($urandom);
        off = 13'(($urandom_range(0, 8) * 4) - 16);
        k   = $urandom_range(0, 12);
        case (k)
            0:  return {7'h00, rs2, rs1, 3'd0, rd, 7'h33};
            1:  return {7'h20, rs2, rs1, 3'd0, rd, 7'h33};
            2:  return {7'h00, rs2, rs1, 3'd2, rd, 7'h33};
            3:  return {7'h00, rs2, rs1, 3'd4, rd, 7'h33};
            4:  return {7'h00, rs2, rs1, 3'd6, rd, 7'h33};
            5:  return {7'h00, rs2, rs1, 3'd7, rd, 7'h33};
            6:  return {imm, rs1, 3'd0, rd, 7'h13};
            7:  return {imm, rs1, 3'd4, rd, 7'h13};
            8:  return {imm, rs1, 3'd6, rd, 7'h13};
            9:  return {imm, rs1, 3'd7, rd, 7'h13};
            10: return {u, rd, 7'h37};
            11: return {off[12], off[10:5], rs2, rs1, 3'd0, off[4:1], off[11], 7'h63};
            default: return {off[12], off[10:5], rs2, rs1, 3'd1, off[4:1], off[11], 7'h63};
        endcase
    endfunction

    task automatic check_halt_and_reset();
        logic [63:0] pc0;
        check64("halt_in_decode", {63'h0, halt}, 64'h0);
        @(negedge clk);
        check64("halt_set", {63'h0, halt}, 64'h1);
        check64("halt_req", {63'h0, imem_req}, 64'h0);
        check64("halt_state", {61'h0, state_out}, 64'h4);
        pc0 = pc_out;
        repeat (5) @(negedge clk);
        check64("halt_sticky", {63'h0, halt}, 64'h1);
        check64("halt_pc", pc_out, pc0);
        rst = 1'b1;
        @(negedge clk);
        check64("rst_halt", {63'h0, halt}, 64'h0);
        check64("rst_req", {63'h0, imem_req}, 64'h0);
        check64("rst_retire", {63'h0, retire}, 64'h0);
        rst = 1'b0;
        sb.delete();
        model_reset();
        @(negedge clk);
        check64("post_rst_pc", pc_out, 64'h0);
        check64("post_rst_halt", {63'h0, halt}, 64'h0);
        check64("post_rst_state", {61'h0, state_out}, 64'h0);
        for (int i = 0; i < 32; i++) check_reg("post_rst_reg", i, 64'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (retire === 1'b1) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_retire: retire=1 with no instruction outstanding (cycle %0d)", cyc);
                end else begin
                    e = sb.pop_front();
                    check64("retire_cycle", 64'(cyc), 64'(e.exp_cyc));
                    dbg_mon = e.rd;
                    @(negedge clk);
                    check64("next_pc", pc_out, e.pc_after);
                    if (e.wr) check64("rd_value", dbg_rdata, e.val);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        bit lg;
        rst        = 1'b1;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        model_reset();
        repeat (2) @(negedge clk);
        check64("rst_req0", {63'h0, imem_req}, 64'h0);
        check64("rst_retire0", {63'h0, retire}, 64'h0);
        check64("rst_halt0", {63'h0, halt}, 64'h0);
        rst = 1'b0;
        @(negedge clk);
        check64("reset_pc", pc_out, 64'h0);
        check64("reset_alu", alu_out, 64'h0);
        check64("reset_state", {61'h0, state_out}, 64'h0);
        check64("reset_req", {63'h0, imem_req}, 64'h1);

        // Directed program
        issue(32'h00500093, 0, lg);
        issue(32'hFFD00113, 0, lg);
        issue(32'h002081B3, 0, lg);
        issue(32'h40110233, 0, lg);
        issue(32'hFE000CE3, 0, lg);
        issue(32'h00700013, 3, lg);
        wait_idle();
        check_reg("x0", 0, 64'h0);
        check_reg("x1", 1, 64'h5);
        check_reg("x2", 2, 64'hFFFF_FFFF_FFFF_FFFD);
        check_reg("x3", 3, 64'h2);
        check_reg("x4", 4, 64'hFFFF_FFFF_FFFF_FFF8);
        check64("pc_after_directed", pc_out, 64'hC);

        // Random program
        for (int i = 0; i < 300; i++) begin
            issue(rand_insn(), $urandom_range(0, 2), lg);
        end
        wait_idle();

        // Reset in the middle of an instruction
        issue(32'h002081B3, 0, lg);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        check64("midrst_retire", {63'h0, retire}, 64'h0);
        check64("midrst_req", {63'h0, imem_req}, 64'h0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        check64("midrst_pc", pc_out, 64'h0);
        check64("midrst_state", {61'h0, state_out}, 64'h0);
        check64("midrst_alu", alu_out, 64'h0);

        // MUL (legal only with UP_MUL_EN), then illegal-instruction halt
        garbage_en = 1'b0;
        issue(32'h00500093, 0, lg);
        issue(32'hFFD00113, 0, lg);
        issue(32'h021081B3, 0, lg);
        if (lg) begin
            wait_idle();
            check_reg("mul_x3", 3, 64'hFFFF_FFFF_FFFF_FFF1);
            issue(32'h00000000, 0, lg);
        end
        check_halt_and_reset();

        check64("sb_drained", 64'(sb.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
